// File: rtl/jstk_pkg.sv
// rtl/jstk_pkg.sv - shared joystick SPI frame layout and FSM encoding
//
// Shared by the responder (this slice) and the master side. Holds the frame
// length, the position of each report byte within the frame, the responder
// FSM state encoding and a helper that packs a report into frame order.
package jstk_pkg;

    localparam int FRAME_BITS  = 40;
    localparam int BYTE_BITS   = 8;
    localparam int FRAME_BYTES = FRAME_BITS / BYTE_BITS;
    localparam int CNT_W       = 6;

    // Byte positions in transmission order (byte 0 goes out first).
    localparam int BYTE_X_LO = 0;
    localparam int BYTE_X_HI = 1;
    localparam int BYTE_Y_LO = 2;
    localparam int BYTE_Y_HI = 3;
    localparam int BYTE_BTN  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } jstk_state_t;

    // Byte k of the frame occupies bits [39-8k -: 8] so that a plain
    // MSB-first left shift emits byte 0 first.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[FRAME_BITS-1-BYTE_X_LO*BYTE_BITS -: BYTE_BITS] = x[7:0];
        f[FRAME_BITS-1-BYTE_X_HI*BYTE_BITS -: BYTE_BITS] = {6'b0, x[9:8]};
        f[FRAME_BITS-1-BYTE_Y_LO*BYTE_BITS -: BYTE_BITS] = y[7:0];
        f[FRAME_BITS-1-BYTE_Y_HI*BYTE_BITS -: BYTE_BITS] = {6'b0, y[9:8]};
        f[FRAME_BITS-1-BYTE_BTN*BYTE_BITS  -: BYTE_BITS] = {5'b0, btn};
        return f;
    endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// rtl/jstk_spi_responder_if.sv - joystick SPI pin bundle with master/slave views
//
// Signals: sck, ss (active-low), mosi driven by the master; miso and
// miso_oe driven by the responder.
interface jstk_spi_responder_if;

    logic sck;
    logic ss;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sck,
        output ss,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sck,
        input  ss,
        input  mosi,
        output miso,
        output miso_oe
    );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop input synchronizer with rise/fall detect
//
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   din        - asynchronous input
//   level      - synchronized level (output of the last sync flop)
//   rise, fall - one-clk pulses, combinational from level vs. edge-detect flop
// STAGES below 2 is raised to 2; RESET_VAL is the level assumed during reset.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] chain;
    logic         prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {N{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[N-2:0], din};
            prev  <= chain[N-1];
        end
    end

    assign level = chain[N-1];
    assign rise  = chain[N-1] & ~prev;
    assign fall  = ~chain[N-1] & prev;

endmodule

// File: rtl/jstk_spi_responder.sv
// rtl/jstk_spi_responder.sv - SPI mode-0 slave reporting joystick position
//
// Ports:
//   clk, rst              - 12 MHz system clock, synchronous active-high reset
//   xpos, ypos, buttons   - joystick report, snapshotted at frame start
//   JSTK_SCK/SS/MOSI      - SPI inputs from the master (SS active-low)
//   JSTK_MISO, miso_oe    - SPI data out and its tristate enable
//   led_cmd               - bits [1:0] of the last complete command byte
//   frame_done            - one-clk pulse as each transaction closes
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] xpos,
    input  logic [9:0] ypos,
    input  logic [2:0] buttons,
    input  logic       JSTK_SCK,
    input  logic       JSTK_SS,
    input  logic       JSTK_MOSI,
    output logic       JSTK_MISO,
    output logic       miso_oe,
    output logic [1:0] led_cmd,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(BYTE_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_BYTE = CNT_W'(BYTE_BITS);
    localparam logic [7:0]       FLUSH_CYCLES = 8'(SYNC_STAGES + 1);

    logic sck_level, sck_rise, sck_fall;
    logic ss_level,  ss_rise,  ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .rst   (rst),
        .din   (JSTK_SCK),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk   (clk),
        .rst   (rst),
        .din   (JSTK_SS),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .din   (JSTK_MOSI),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_level, mosi_rise, mosi_fall};

    // The SS synchronizer resets to "high". If SS is actually low when reset
    // releases, the chain flushing to 0 looks like a falling edge. Frames are
    // only accepted once SS has been seen high after the flush, so a reset
    // mid-frame waits for a genuine new SS fall.
    logic [7:0] flush_cnt;
    logic       armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= FLUSH_CYCLES;
            armed     <= 1'b0;
        end else if (flush_cnt != 8'd0) begin
            flush_cnt <= flush_cnt - 8'd1;
        end else if (ss_level) begin
            armed <= 1'b1;
        end
    end

    jstk_state_t state, state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ss_fall && armed) state_next = ST_LOAD;
            // A runt SS pulse can end during LOAD; close the frame directly.
            ST_LOAD:  state_next = ss_rise ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (ss_rise) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    logic [FRAME_BITS-1:0] tx;
    logic [FRAME_BITS-1:0] snap;
    logic [BYTE_BITS-1:0]  rx;
    logic [CNT_W-1:0]      bit_cnt;
    logic [1:0]            pending;
    logic                  miso_q;

    assign snap = pack_frame(xpos, ypos, buttons);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx      <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            pending <= 2'b00;
            miso_q  <= 1'b0;
            led_cmd <= 2'b00;
        end else begin
            case (state)
                ST_LOAD: begin
                    // Snapshot once; the report is frozen for the whole frame.
                    tx      <= snap;
                    miso_q  <= snap[FRAME_BITS-1];
                    rx      <= '0;
                    bit_cnt <= '0;
                end
                ST_SHIFT: begin
                    if (!ss_rise) begin
                        if (sck_rise) begin
                            rx <= {rx[BYTE_BITS-2:0], mosi_level};
                            if (bit_cnt < CNT_MAX) begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                            // 8th rising edge: rx holds bits 7..1, mosi is bit 0.
                            if (bit_cnt == CNT_CMD_LAST) begin
                                pending <= {rx[0], mosi_level};
                            end
                        end
                        if (sck_fall) begin
                            tx     <= {tx[FRAME_BITS-2:0], 1'b0};
                            miso_q <= tx[FRAME_BITS-2];
                        end
                    end
                end
                ST_DONE: begin
                    if (bit_cnt >= CNT_ONE_BYTE) begin
                        led_cmd <= pending;
                    end
                    miso_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign miso_oe    = (state == ST_LOAD) || (state == ST_SHIFT);
    assign JSTK_MISO  = miso_q & miso_oe;
    assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb/tb_jstk_spi_responder.sv - scoreboard bench for jstk_spi_responder
module tb_jstk_spi_responder;

    // 90 system clocks per SCK half period: 12 MHz / 180 = 66.7 kHz.
    localparam int SCK_HALF = 90;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic [2:0] buttons;
    logic [1:0] led_cmd;
    logic       frame_done;

    always #5 clk = ~clk;

    jstk_spi_responder_if spi ();

    jstk_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .xpos       (xpos),
        .ypos       (ypos),
        .buttons    (buttons),
        .JSTK_SCK   (spi.sck),
        .JSTK_SS    (spi.ss),
        .JSTK_MOSI  (spi.mosi),
        .JSTK_MISO  (spi.miso),
        .miso_oe    (spi.miso_oe),
        .led_cmd    (led_cmd),
        .frame_done (frame_done)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         fd_count = 0;
    int         quiet_viol = 0;
    bit         watch_quiet = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_buf[0:5];

    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (watch_quiet && (spi.miso_oe || spi.miso)) quiet_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [9:0] x, input logic [9:0] y,
                                              input logic [2:0] b, input int k);
        case (k)
            0:       return x[7:0];
            1:       return {6'b000000, x[9:8]};
            2:       return y[7:0];
            3:       return {6'b000000, y[9:8]};
            4:       return {5'b00000, b};
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_frame(input logic [9:0] x, input logic [9:0] y,
                              input logic [2:0] b, input int nbytes);
        for (int k = 0; k < nbytes; k++) exp_q.push_back(model_byte(x, y, b, k));
    endtask

    task automatic drain(input int nbytes);
        logic [7:0] e;
        for (int k = 0; k < nbytes; k++) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("byte%0d", k), {24'd0, rx_buf[k]}, {24'd0, e});
            end
        end
    endtask

    // Mode 0 master: MOSI set during the low phase, MISO sampled at the rise.
    task automatic run_frame(input int nbits, input logic [7:0] cmd,
                             input int hold_at, input int rst_at);
        logic mi;
        for (int k = 0; k < 6; k++) rx_buf[k] = 8'h00;
        spi.ss = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = (i < 8) ? cmd[7-i] : 1'b0;
            repeat (SCK_HALF) @(negedge clk);
            mi = spi.miso;
            spi.sck = 1'b1;
            if (i < 48) rx_buf[i/8] = {rx_buf[i/8][6:0], mi};
            repeat (SCK_HALF) @(negedge clk);
            spi.sck = 1'b0;
            if (i == hold_at) xpos = 10'h000;
            if (i == rst_at) begin
                @(negedge clk) rst = 1'b1;
                @(negedge clk) rst = 1'b0;
                repeat (6) @(negedge clk);
                check("rst_led", {30'd0, led_cmd}, 32'd0);
                check("rst_miso", {31'd0, spi.miso}, 32'd0);
                check("rst_oe", {31'd0, spi.miso_oe}, 32'd0);
                watch_quiet = 1'b1;
            end
        end
        spi.mosi = 1'b0;
        repeat (SCK_HALF) @(negedge clk);
        spi.ss = 1'b1;
        repeat (SCK_HALF) @(negedge clk);
    endtask

    int fd0;

    initial begin
        spi.ss   = 1'b1;
        spi.sck  = 1'b0;
        spi.mosi = 1'b0;
        xpos     = 10'h2A5;
        ypos     = 10'h17F;
        buttons  = 3'b101;
        repeat (5) @(negedge clk);
        check("reset_led", {30'd0, led_cmd}, 32'd0);
        check("reset_oe", {31'd0, spi.miso_oe}, 32'd0);
        check("reset_miso", {31'd0, spi.miso}, 32'd0);
        check("reset_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Full frame.
        fd0 = fd_count;
        push_frame(10'h2A5, 10'h17F, 3'b101, 5);
        run_frame(40, 8'h03, -1, -1);
        drain(5);
        check("full_led", {30'd0, led_cmd}, 32'd3);
        check("full_fd", fd_count - fd0, 32'd1);

        // Snapshot hold: X cleared after the 3rd SCK.
        push_frame(10'h2A5, 10'h17F, 3'b101, 5);
        run_frame(40, 8'h03, 2, -1);
        xpos = 10'h2A5;
        drain(5);

        // Abort after 5 bits, then a fresh full frame.
        fd0 = fd_count;
        run_frame(5, 8'h00, -1, -1);
        check("abort_fd", fd_count - fd0, 32'd1);
        check("abort_led", {30'd0, led_cmd}, 32'd3);
        xpos = 10'h155; ypos = 10'h2AA; buttons = 3'b011;
        fd0 = fd_count;
        push_frame(10'h155, 10'h2AA, 3'b011, 5);
        run_frame(40, 8'h02, -1, -1);
        drain(5);
        check("post_abort_led", {30'd0, led_cmd}, 32'd2);
        check("post_abort_fd", fd_count - fd0, 32'd1);

        // Over-length frame: byte 5 must be all zeros.
        push_frame(10'h155, 10'h2AA, 3'b011, 6);
        run_frame(48, 8'h01, -1, -1);
        drain(6);
        check("over_led", {30'd0, led_cmd}, 32'd1);

        // Reset after 20 bits: frame abandoned, bus quiet until next SS fall.
        fd0 = fd_count;
        quiet_viol = 0;
        run_frame(40, 8'h03, -1, 19);
        watch_quiet = 1'b0;
        check("rst_fd", fd_count - fd0, 32'd0);
        check("rst_led_end", {30'd0, led_cmd}, 32'd0);
        check("rst_quiet", quiet_viol, 32'd0);

        // SCK toggling with SS high.
        fd0 = fd_count;
        quiet_viol = 0;
        watch_quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            spi.sck = 1'b1;
            repeat (SCK_HALF / 3) @(negedge clk);
            spi.sck = 1'b0;
            repeat (SCK_HALF / 3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        watch_quiet = 1'b0;
        check("idle_quiet", quiet_viol, 32'd0);
        check("idle_fd", fd_count - fd0, 32'd0);
        check("idle_led", {30'd0, led_cmd}, 32'd0);

        // Frame after reset with different data.
        xpos = 10'h3FF; ypos = 10'h000; buttons = 3'b010;
        fd0 = fd_count;
        push_frame(10'h3FF, 10'h000, 3'b010, 5);
        run_frame(40, 8'hFE, -1, -1);
        drain(5);
        check("final_led", {30'd0, led_cmd}, 32'd2);
        check("final_fd", fd_count - fd0, 32'd1);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jstk_spi_responder.md
JSTK_SPI_RESPONDER -- requirements
Module: jstk_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the flop count of the synchronizer on each of SCK, SS and MOSI (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: 12 MHz system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port xpos, input, 10 bits: joystick X value 0..1023 to report.
REQ-005 SHALL have port ypos, input, 10 bits: joystick Y value 0..1023 to report.
REQ-006 SHALL have port buttons, input, 3 bits: {trigger, btn2, btn1}, 1 = pressed.
REQ-007 SHALL have port JSTK_SCK, input, 1 bit: SPI clock from the master.
REQ-008 SHALL have port JSTK_SS, input, 1 bit: slave select, active-low.
REQ-009 SHALL have port JSTK_MOSI, input, 1 bit: master-out data.
REQ-010 SHALL have port JSTK_MISO, output, 1 bit: slave-out data.
REQ-011 SHALL have port miso_oe, output, 1 bit: MISO drive enable (tristate at top level).
REQ-012 SHALL have port led_cmd, output, 2 bits: LED bits [1:0] of the last completed command byte.
REQ-013 SHALL have port frame_done, output, 1 bit: one-clk pulse at the end of each transaction.

Function
REQ-014 SHALL implement SPI mode 0, MSB first: sample MOSI on synchronized SCK rising, update MISO on synchronized SCK falling.
REQ-015 SHALL run SCK/SS/MOSI through SYNC_STAGES flops, then one edge-detect flop; synchronized-edge-to-action latency is SYNC_STAGES+1 clk.
REQ-016 SHALL have FSM states IDLE (SS high), LOAD (one clk after SS falling), SHIFT (SS low), DONE (one clk after SS rising, then back to IDLE).
REQ-017 SHALL, in LOAD, snapshot xpos, ypos and buttons into a 40-bit TX register: byte0=X[7:0], byte1={6'b0,X[9:8]}, byte2=Y[7:0], byte3={6'b0,Y[9:8]}, byte4={5'b0,buttons}.
REQ-018 SHALL drive bit 39 of the TX register on JSTK_MISO at the end of LOAD, so it is valid before the first SCK rising edge.
REQ-019 SHALL shift the TX register left by one on each SCK falling edge and fill the vacated bit with 0, so MISO outputs 0 after the 40th bit.
REQ-020 SHALL count received bits in a 6-bit saturating counter (saturates at 40) and shift MOSI into an 8-bit RX register.
REQ-021 SHALL, on the 8th SCK rising edge of a frame, latch RX[1:0] into a pending register; later bytes are discarded.
REQ-022 SHALL, in DONE, copy the pending register to led_cmd only if at least 8 bits were received, and SHALL pulse frame_done for exactly one clk regardless of bit count.
REQ-023 SHALL drive miso_oe=1 in LOAD and SHIFT and 0 otherwise; JSTK_MISO SHALL be 0 while miso_oe=0.
REQ-024 SHALL ignore SCK edges while synchronized SS is high.
REQ-025 SHALL treat an SS rise mid-byte as an abort: go to DONE, apply REQ-022, and let the next SS fall restart from LOAD with a fresh snapshot.
REQ-026 SHALL, if an SS fall and an SCK edge are detected in the same clk, process LOAD and ignore that SCK edge.
REQ-027 SHALL NOT let changes on xpos, ypos or buttons during SHIFT affect the frame in progress.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, set the state to IDLE; set JSTK_MISO, miso_oe, frame_done and the bit counter to 0; set led_cmd to 2'b00; and set the synchronizers to SS=1, SCK=0, MOSI=0.
REQ-029 SHALL, when rst is asserted mid-frame, abandon the frame without a frame_done pulse, and SHALL begin the next frame only after a new SS falling edge.

Structure
REQ-030 SHALL place the frame length (40 bits), the byte-position constants and the FSM state encoding in the shared jstk_pkg package also used by the master side.
REQ-031 SHALL instantiate one sub-module, sync_edge, per input, providing the synchronized level plus rise and fall pulses.

Verification
REQ-032 SHALL cover a full frame: xpos=10'h2A5, ypos=10'h17F, buttons=3'b101, master sends 8'h03,0,0,0,0 at 66.7 kHz SCK -> master receives A5,02,7F,01,05; led_cmd=2'b11; one frame_done pulse.
REQ-033 SHALL cover a snapshot hold: xpos changes to 10'h000 after the 3rd SCK -> received bytes are still A5,02.
REQ-034 SHALL cover an abort: SS rises after 5 bits -> frame_done pulses once, led_cmd is unchanged, the next full frame is correct.
REQ-035 SHALL cover an over-length frame: 48 SCK cycles -> bytes 0..4 are correct and byte 5 is 8'h00.
REQ-036 SHALL cover reset mid-frame: rst for 1 clk after 20 bits -> no frame_done pulse, led_cmd=00, MISO=0 and miso_oe=0 until the next SS fall.
REQ-037 SHALL cover idle behaviour: SCK toggles while SS is high -> no state change and miso_oe stays 0.
